lpif_x4_half_rate_packer: RTL and testbench
===========================================

LPIF_X4_HALF_RATE_PACKER -- requirements
Module: lpif_x4_half_rate_packer

Interface
Parameters:
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 8: number of cycles a lone beat is held before a partial word is emitted; 0 disables the timeout.

Ports:
REQ-002 SHALL have lclk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have beat input ports:
- in_state, input, 4
- in_protid, input, 2
- in_data, input, 128
- in_dvalid, input, 1
- in_crc, input, 4
- in_crc_valid, input, 1
REQ-005 SHALL have in_valid, input, 1: a beat is offered.
REQ-006 SHALL have in_ready, output, 1: a beat is accepted when in_valid and in_ready are both 1.
REQ-007 SHALL have flush, input, 1: request to emit a held lone beat immediately.
REQ-008 SHALL have packed output ports:
- dstrm_state, output, 8
- dstrm_protid, output, 4
- dstrm_data, output, 256
- dstrm_dvalid, output, 2
- dstrm_crc, output, 8
- dstrm_crc_valid, output, 2
- dstrm_valid, output, 2
REQ-009 SHALL have dstrm_push, output, 1: the packed word is transferred this cycle.
REQ-010 SHALL have dstrm_ready, input, 1: the downstream channel can take a word.
REQ-011 SHALL have partial_cnt, output, 16: saturating count of partial words emitted.

Function
REQ-012 SHALL implement a state machine with states IDLE (nothing held), HALF (slot 0 held) and OUT (packed word presented).
REQ-013 SHALL drive in_ready = (state != OUT) | dstrm_ready, giving one beat per cycle sustained throughput.
REQ-014 SHALL drive dstrm_push = (state == OUT) & dstrm_ready.
REQ-015 SHALL, on accept in IDLE, store the beat in slot 0 and go to HALF.
REQ-016 SHALL, on accept in HALF, load the output register and go to OUT:
- slot 0 occupies the lower half of each field (state[3:0], protid[1:0], data[127:0], bit 0 of dvalid, crc_valid and valid);
- the accepted beat occupies the upper half;
- dstrm_valid = 2'b11.
REQ-017 SHALL, in HALF with no accept and either flush=1 or the hold timer equal to FLUSH_TIMEOUT (FLUSH_TIMEOUT != 0), emit a partial word and go to OUT:
- slot 0 in the lower half;
- upper half of every field zero;
- dstrm_valid = 2'b01.
REQ-018 SHALL give accept priority over flush and timeout when they coincide in HALF; the result is a full word.
REQ-019 SHALL ignore flush in IDLE and in OUT.
REQ-020 SHALL run the hold timer as follows:
- clears on entry to HALF;
- increments each cycle in HALF;
- never exceeds FLUSH_TIMEOUT.
REQ-021 SHALL, in OUT with dstrm_push:
- go to HALF if a beat is accepted in the same cycle, storing it in slot 0;
- otherwise go to IDLE.
REQ-022 SHALL, in OUT with dstrm_ready=0, hold every dstrm_* field stable and keep in_ready=0.
REQ-023 SHALL keep dstrm_* fields at their last loaded value outside OUT; consumers qualify them with dstrm_push only.
REQ-024 SHALL have a latency from accept of the second beat (cycle N) to the earliest dstrm_push of cycle N+1.
REQ-025 SHALL increment partial_cnt on each dstrm_push of a partial word and saturate at 16'hFFFF.

Reset
REQ-026 SHALL, while reset=1, force asynchronously:
- state = IDLE;
- slot 0, output register, hold timer and partial_cnt to zero;
- therefore in_ready=1, dstrm_push=0 and every dstrm_* output zero.
REQ-027 SHALL discard any held or presented beat when reset asserts mid-operation; no push occurs for it after reset release.
REQ-028 SHALL accept a beat on the first rising edge after reset deasserts.

Verification
REQ-029 SHALL pass these directed scenarios:
- Back-to-back, dstrm_ready=1: beats A (data=128'h1, state=4'h3), B (data=128'h2, state=4'h5) -> next cycle dstrm_push=1, dstrm_data={128'h2,128'h1}, dstrm_state=8'h53, dstrm_valid=2'b11; 8 continuous beats -> 4 pushes, in_ready never 0.
- Backpressure: dstrm_ready=0 for 5 cycles after a full word -> in_ready=0 and outputs stable for 5 cycles; dstrm_ready=1 -> one push, then in_ready=1.
- Timeout, FLUSH_TIMEOUT=8: single beat, then idle -> push at hold-timer 8 with dstrm_valid=2'b01, upper 128 data bits zero, partial_cnt=1.
- Flush vs accept: flush=1 and in_valid=1 in the same HALF cycle -> full word with dstrm_valid=2'b11, partial_cnt unchanged; flush in IDLE -> no push.
- Reset mid-OUT with dstrm_ready=0: reset pulse -> dstrm_push=0, all outputs zero, in_ready=1; the next two beats form a fresh full word.

Source files
------------

// File: rtl/lpif_x4_half_rate_packer.sv
// Packs two consecutive LPIF beats into one double-width word for a half-rate
// downstream; a lone beat is emitted as a partial word on flush or hold timeout.
//
// state | meaning
// IDLE  | nothing held
// HALF  | slot 0 holds one beat, waiting for its partner
// OUT   | packed word presented on dstrm_*, waiting for dstrm_ready
module lpif_x4_half_rate_packer #(
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic         lclk,
    input  logic         reset,
    input  logic [3:0]   in_state,
    input  logic [1:0]   in_protid,
    input  logic [127:0] in_data,
    input  logic         in_dvalid,
    input  logic [3:0]   in_crc,
    input  logic         in_crc_valid,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [7:0]   dstrm_state,
    output logic [3:0]   dstrm_protid,
    output logic [255:0] dstrm_data,
    output logic [1:0]   dstrm_dvalid,
    output logic [7:0]   dstrm_crc,
    output logic [1:0]   dstrm_crc_valid,
    output logic [1:0]   dstrm_valid,
    output logic         dstrm_push,
    input  logic         dstrm_ready,
    output logic [15:0]  partial_cnt
);

    localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALF = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]    slot_state;
    logic [1:0]    slot_protid;
    logic [127:0]  slot_data;
    logic          slot_dvalid;
    logic [3:0]    slot_crc;
    logic          slot_crc_valid;
    logic [TW-1:0] hold_timer;
    logic          out_partial;

    logic accept;
    logic timed_out;
    logic load_slot;
    logic emit_full;
    logic emit_partial;

    assign in_ready   = (state != OUT) | dstrm_ready;
    assign dstrm_push = (state == OUT) & dstrm_ready;
    assign accept     = in_valid & in_ready;
    assign timed_out  = (FLUSH_TIMEOUT != 0) && (hold_timer == TIMER_MAX);

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_slot    = 1'b0;
        emit_full    = 1'b0;
        emit_partial = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    load_slot = 1'b1;
                    state_nxt = HALF;
                end
            end
            HALF: begin
                // a real partner beat always wins over flush/timeout
                if (accept) begin
                    emit_full = 1'b1;
                    state_nxt = OUT;
                end else if (flush || timed_out) begin
                    emit_partial = 1'b1;
                    state_nxt    = OUT;
                end
            end
            OUT: begin
                if (dstrm_push) begin
                    if (accept) begin
                        load_slot = 1'b1;
                        state_nxt = HALF;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            slot_state     <= '0;
            slot_protid    <= '0;
            slot_data      <= '0;
            slot_dvalid    <= 1'b0;
            slot_crc       <= '0;
            slot_crc_valid <= 1'b0;
        end else if (load_slot) begin
            slot_state     <= in_state;
            slot_protid    <= in_protid;
            slot_data      <= in_data;
            slot_dvalid    <= in_dvalid;
            slot_crc       <= in_crc;
            slot_crc_valid <= in_crc_valid;
        end
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            hold_timer <= '0;
        end else if (load_slot) begin
            hold_timer <= '0;
        end else if (state == HALF && hold_timer != TIMER_MAX) begin
            hold_timer <= hold_timer + 1'b1;
        end
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            dstrm_state     <= '0;
            dstrm_protid    <= '0;
            dstrm_data      <= '0;
            dstrm_dvalid    <= '0;
            dstrm_crc       <= '0;
            dstrm_crc_valid <= '0;
            dstrm_valid     <= '0;
            out_partial     <= 1'b0;
        end else if (emit_full) begin
            dstrm_state     <= {in_state, slot_state};
            dstrm_protid    <= {in_protid, slot_protid};
            dstrm_data      <= {in_data, slot_data};
            dstrm_dvalid    <= {in_dvalid, slot_dvalid};
            dstrm_crc       <= {in_crc, slot_crc};
            dstrm_crc_valid <= {in_crc_valid, slot_crc_valid};
            dstrm_valid     <= 2'b11;
            out_partial     <= 1'b0;
        end else if (emit_partial) begin
            dstrm_state     <= {4'h0, slot_state};
            dstrm_protid    <= {2'h0, slot_protid};
            dstrm_data      <= {128'h0, slot_data};
            dstrm_dvalid    <= {1'b0, slot_dvalid};
            dstrm_crc       <= {4'h0, slot_crc};
            dstrm_crc_valid <= {1'b0, slot_crc_valid};
            dstrm_valid     <= 2'b01;
            out_partial     <= 1'b1;
        end
    end

    always_ff @(posedge lclk or posedge reset) begin
        if (reset) begin
            partial_cnt <= '0;
        end else if (dstrm_push && out_partial && partial_cnt != 16'hFFFF) begin
            partial_cnt <= partial_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lpif_x4_half_rate_packer.sv
// Directed bench for lpif_x4_half_rate_packer: pairing, backpressure, timeout,
// flush priority and mid-operation reset, with hand-computed expectations.
module tb_lpif_x4_half_rate_packer;

    logic         lclk;
    logic         reset;
    logic [3:0]   in_state;
    logic [1:0]   in_protid;
    logic [127:0] in_data;
    logic         in_dvalid;
    logic [3:0]   in_crc;
    logic         in_crc_valid;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [7:0]   dstrm_state;
    logic [3:0]   dstrm_protid;
    logic [255:0] dstrm_data;
    logic [1:0]   dstrm_dvalid;
    logic [7:0]   dstrm_crc;
    logic [1:0]   dstrm_crc_valid;
    logic [1:0]   dstrm_valid;
    logic         dstrm_push;
    logic         dstrm_ready;
    logic [15:0]  partial_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int push_seen;

    lpif_x4_half_rate_packer #(.FLUSH_TIMEOUT(8)) dut (
        .lclk            (lclk),
        .reset           (reset),
        .in_state        (in_state),
        .in_protid       (in_protid),
        .in_data         (in_data),
        .in_dvalid       (in_dvalid),
        .in_crc          (in_crc),
        .in_crc_valid    (in_crc_valid),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .dstrm_state     (dstrm_state),
        .dstrm_protid    (dstrm_protid),
        .dstrm_data      (dstrm_data),
        .dstrm_dvalid    (dstrm_dvalid),
        .dstrm_crc       (dstrm_crc),
        .dstrm_crc_valid (dstrm_crc_valid),
        .dstrm_valid     (dstrm_valid),
        .dstrm_push      (dstrm_push),
        .dstrm_ready     (dstrm_ready),
        .partial_cnt     (partial_cnt)
    );

    initial lclk = 1'b0;
    always #5 lclk = ~lclk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge lclk);
        #1;
    endtask

    task automatic drive(input logic [127:0] d, input logic [3:0] st, input logic [1:0] pid,
                         input logic dv, input logic [3:0] c, input logic cv);
        in_valid     = 1'b1;
        in_data      = d;
        in_state     = st;
        in_protid    = pid;
        in_dvalid    = dv;
        in_crc       = c;
        in_crc_valid = cv;
    endtask

    task automatic idle_in();
        in_valid     = 1'b0;
        in_data      = '0;
        in_state     = '0;
        in_protid    = '0;
        in_dvalid    = 1'b0;
        in_crc       = '0;
        in_crc_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_in();
        flush       = 1'b0;
        dstrm_ready = 1'b1;
        reset       = 1'b1;
        repeat (3) @(posedge lclk);
        #1;
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        chk("rst_push", 256'(dstrm_push), 256'(0));
        chk("rst_data", dstrm_data, 256'(0));
        chk("rst_valid", 256'(dstrm_valid), 256'(0));
        chk("rst_pcnt", 256'(partial_cnt), 256'(0));
        reset = 1'b0;

        // back-to-back pair with sideband packing
        drive(128'h1, 4'h3, 2'h1, 1'b1, 4'hA, 1'b1);
        #1;
        chk("a_in_ready", 256'(in_ready), 256'(1));
        tick();
        drive(128'h2, 4'h5, 2'h2, 1'b1, 4'h5, 1'b0);
        tick();
        idle_in();
        #1;
        chk("ab_push", 256'(dstrm_push), 256'(1));
        chk("ab_data", dstrm_data, {128'h2, 128'h1});
        chk("ab_state", 256'(dstrm_state), 256'(8'h53));
        chk("ab_valid", 256'(dstrm_valid), 256'(2'b11));
        chk("ab_protid", 256'(dstrm_protid), 256'(4'h9));
        chk("ab_dvalid", 256'(dstrm_dvalid), 256'(2'b11));
        chk("ab_crc", 256'(dstrm_crc), 256'(8'h5A));
        chk("ab_crc_valid", 256'(dstrm_crc_valid), 256'(2'b01));
        tick();
        chk("ab_after_push", 256'(dstrm_push), 256'(0));

        // eight continuous beats -> four pushes, never stalled
        push_seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(128'(i + 16), 4'(i), 2'h0, 1'b1, 4'h0, 1'b0);
            #1;
            chk("stream_in_ready", 256'(in_ready), 256'(1));
            if (dstrm_push) push_seen++;
            tick();
        end
        idle_in();
        #1;
        if (dstrm_push) push_seen++;
        chk("stream_last_data", dstrm_data, {128'd23, 128'd22});
        chk("stream_last_state", 256'(dstrm_state), 256'(8'h76));
        chk("stream_pushes", 256'(push_seen), 256'(4));
        tick();

        // backpressure for 5 cycles on a full word
        drive(128'hC, 4'h1, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        drive(128'hD, 4'h2, 2'h0, 1'b1, 4'h0, 1'b0);
        dstrm_ready = 1'b0;
        tick();
        drive(128'hE, 4'h4, 2'h0, 1'b1, 4'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 256'(in_ready), 256'(0));
            chk("bp_push", 256'(dstrm_push), 256'(0));
            chk("bp_data", dstrm_data, {128'hD, 128'hC});
            chk("bp_state", 256'(dstrm_state), 256'(8'h21));
            tick();
        end
        idle_in();
        dstrm_ready = 1'b1;
        #1;
        chk("bp_release_push", 256'(dstrm_push), 256'(1));
        chk("bp_release_data", dstrm_data, {128'hD, 128'hC});
        tick();
        chk("bp_after_in_ready", 256'(in_ready), 256'(1));
        chk("bp_after_push", 256'(dstrm_push), 256'(0));

        // lone beat times out after the hold timer reaches 8
        drive(128'hF0F0, 4'h7, 2'h3, 1'b1, 4'h6, 1'b1);
        tick();
        idle_in();
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("to_wait_push", 256'(dstrm_push), 256'(0));
            tick();
        end
        chk("to_push", 256'(dstrm_push), 256'(1));
        chk("to_valid", 256'(dstrm_valid), 256'(2'b01));
        chk("to_data", dstrm_data, {128'h0, 128'hF0F0});
        chk("to_state", 256'(dstrm_state), 256'(8'h07));
        chk("to_protid", 256'(dstrm_protid), 256'(4'h3));
        chk("to_crc", 256'(dstrm_crc), 256'(8'h06));
        chk("to_crc_valid", 256'(dstrm_crc_valid), 256'(2'b01));
        tick();
        chk("to_pcnt", 256'(partial_cnt), 256'(1));
        chk("to_after_push", 256'(dstrm_push), 256'(0));

        // flush coinciding with accept yields a full word
        drive(128'h10, 4'h8, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        drive(128'h11, 4'h9, 2'h0, 1'b1, 4'h0, 1'b0);
        flush = 1'b1;
        tick();
        idle_in();
        flush = 1'b0;
        #1;
        chk("fa_push", 256'(dstrm_push), 256'(1));
        chk("fa_valid", 256'(dstrm_valid), 256'(2'b11));
        chk("fa_data", dstrm_data, {128'h11, 128'h10});
        tick();
        chk("fa_pcnt", 256'(partial_cnt), 256'(1));

        // flush in IDLE is ignored
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fi_push", 256'(dstrm_push), 256'(0));
            tick();
        end
        flush = 1'b0;
        chk("fi_pcnt", 256'(partial_cnt), 256'(1));

        // explicit flush of a lone beat
        drive(128'h22, 4'hB, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        idle_in();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_push", 256'(dstrm_push), 256'(1));
        chk("fl_valid", 256'(dstrm_valid), 256'(2'b01));
        chk("fl_data", dstrm_data, {128'h0, 128'h22});
        tick();
        chk("fl_pcnt", 256'(partial_cnt), 256'(2));

        // reset while a word is stalled in OUT
        drive(128'h30, 4'h1, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        drive(128'h31, 4'h2, 2'h0, 1'b1, 4'h0, 1'b0);
        dstrm_ready = 1'b0;
        tick();
        idle_in();
        #1;
        chk("mr_stalled_in_ready", 256'(in_ready), 256'(0));
        reset = 1'b1;
        #1;
        chk("mr_push", 256'(dstrm_push), 256'(0));
        chk("mr_in_ready", 256'(in_ready), 256'(1));
        chk("mr_data", dstrm_data, 256'(0));
        chk("mr_valid", 256'(dstrm_valid), 256'(0));
        chk("mr_state", 256'(dstrm_state), 256'(0));
        chk("mr_pcnt", 256'(partial_cnt), 256'(0));
        tick();
        reset       = 1'b0;
        dstrm_ready = 1'b1;
        #1;
        chk("mr_release_push", 256'(dstrm_push), 256'(0));
        drive(128'h40, 4'hC, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        drive(128'h41, 4'hD, 2'h0, 1'b1, 4'h0, 1'b0);
        tick();
        idle_in();
        #1;
        chk("mr_fresh_push", 256'(dstrm_push), 256'(1));
        chk("mr_fresh_data", dstrm_data, {128'h41, 128'h40});
        chk("mr_fresh_valid", 256'(dstrm_valid), 256'(2'b11));
        chk("mr_fresh_state", 256'(dstrm_state), 256'(8'hDC));
        tick();
        chk("mr_fresh_after", 256'(dstrm_push), 256'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
